alu_seq: RTL and testbench

- Parametrised, handshaked successor to the team's 8-bit combinational ALU.
- Keeps the 16-entry 4-bit opcode set and adds four things:
  - WIDTH generalisation.
  - valid/ready handshakes on input and output.
  - Registered result plus a full flag set.
  - Iterative multi-cycle multiply and divide.
- Sits between an operand source (sequencer or register file) and a result consumer.
- One operation in flight at a time.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_iter_muldiv.sv | 75 +++++++
 rtl/alu_seq.sv | 154 +++++++++++++++
 tb/tb_alu_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg -- opcode constants, FSM states and iterative-engine modes shared by the ALU family.
// Rev 1.0
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_ROL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_NAND = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;
  localparam logic [3:0] OP_GT   = 4'd14;
  localparam logic [3:0] OP_EQ   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_mode_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
`default_nettype none
// alu_iter_muldiv -- WIDTH-cycle shift-add multiplier / restoring divider.
// Rev 1.0
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  md_mode_t         mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  md_mode_t         r_mode;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_b;
  logic             r_dz;

  logic [WIDTH:0]   w_madd;
  logic [WIDTH:0]   w_dt;
  logic             w_dge;
  logic [WIDTH-1:0] w_ddiff;

  // lo/hi carry the multiplier (a) / dividend bits and the partial product / remainder.
  assign w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_dt    = {r_hi, r_lo[WIDTH-1]};
  assign w_dge   = w_dt >= {1'b0, r_b};
  assign w_ddiff = w_dt[WIDTH-1:0] - r_b;

  // Outputs are the post-step values so the caller can register them on the final step.
  assign lo = (r_mode == MD_DIV) ? {r_lo[WIDTH-2:0], w_dge} : {w_madd[0], r_lo[WIDTH-1:1]};
  assign hi = (r_mode == MD_DIV) ? (w_dge ? w_ddiff : w_dt[WIDTH-1:0]) : w_madd[WIDTH:1];

  assign done        = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign div_by_zero = r_dz;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_mode <= MD_MUL;
      r_lo   <= '0;
      r_hi   <= '0;
      r_b    <= '0;
      r_dz   <= 1'b0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_mode <= mode;
      r_lo   <= a;
      r_hi   <= '0;
      r_b    <= b;
      r_dz   <= (mode == MD_DIV) && (b == '0);
    end else if (r_busy) begin
      r_lo  <= lo;
      r_hi  <= hi;
      r_cnt <= r_cnt + CW'(1);
      if (done) r_busy <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// alu_seq -- handshaked WIDTH-bit ALU with registered result/flags and iterative mul/div.
// Rev 1.0
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             busy
);

  state_t           r_state;
  logic             r_is_div;

  logic             w_accept;
  logic             w_iter;
  logic             w_eng_done;
  logic [WIDTH-1:0] w_eng_lo;
  logic [WIDTH-1:0] w_eng_hi;
  logic             w_eng_dz;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;

  assign in_ready  = (r_state == ST_IDLE) && !rst;
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_iter    = is_iterative(sel);

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk         (clk),
    .rst         (rst),
    .start       (w_accept && w_iter),
    .mode        ((sel == OP_DIV) ? MD_DIV : MD_MUL),
    .a           (a),
    .b           (b),
    .done        (w_eng_done),
    .lo          (w_eng_lo),
    .hi          (w_eng_hi),
    .div_by_zero (w_eng_dz)
  );

  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (sel)
      OP_ADD: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_sub[WIDTH-1:0];
        w_carry = w_sub[WIDTH];
        w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: begin
        w_res   = {a[WIDTH-2:0], 1'b0};
        w_carry = a[WIDTH-1];
      end
      OP_SHR: begin
        w_res   = {1'b0, a[WIDTH-1:1]};
        w_carry = a[0];
      end
      OP_ROL:  w_res = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  w_res = {a[0], a[WIDTH-1:1]};
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_NOR:  w_res = ~(a | b);
      OP_NAND: w_res = ~(a & b);
      OP_XNOR: w_res = ~(a ^ b);
      OP_GT:   w_res = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (a == b)};
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_is_div    <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      carry       <= 1'b0;
      zero        <= 1'b0;
      negative    <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_iter) begin
              r_state  <= ST_BUSY;
              r_is_div <= (sel == OP_DIV);
            end else begin
              r_state     <= ST_DONE;
              result      <= w_res;
              result_hi   <= '0;
              carry       <= w_carry;
              zero        <= (w_res == '0);
              negative    <= w_res[WIDTH-1];
              overflow    <= w_ovf;
              div_by_zero <= 1'b0;
            end
          end
        end
        ST_BUSY: begin
          if (w_eng_done) begin
            r_state     <= ST_DONE;
            result      <= w_eng_lo;
            result_hi   <= w_eng_hi;
            carry       <= !r_is_div && (w_eng_hi != '0);
            zero        <= r_is_div ? (w_eng_lo == '0) : ({w_eng_hi, w_eng_lo} == '0);
            negative    <= w_eng_lo[WIDTH-1];
            overflow    <= 1'b0;
            div_by_zero <= r_is_div && w_eng_dz;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// tb_alu_seq -- randomized self-checking bench for alu_seq against an arithmetic reference model.
// Rev 1.0
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W     = 8;
  localparam int LIMIT = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         carry;
  logic         zero;
  logic         negative;
  logic         overflow;
  logic         div_by_zero;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .sel         (sel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_hi   (result_hi),
    .carry       (carry),
    .zero        (zero),
    .negative    (negative),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
    logic         dz;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] op);
    exp_t e;
    int ux, uy, sx, sy, full, smax, smin;
    ux   = int'(x);
    uy   = int'(y);
    sx   = int'($signed(x));
    sy   = int'($signed(y));
    smax = (1 << (W - 1)) - 1;
    smin = -(1 << (W - 1));
    e    = '0;
    case (op)
      OP_ADD: begin
        full  = ux + uy;
        e.res = W'(full);
        e.c   = full >= (1 << W);
        e.v   = (sx + sy > smax) || (sx + sy < smin);
      end
      OP_SUB: begin
        full  = ux - uy;
        e.res = W'(full);
        e.c   = ux < uy;
        e.v   = (sx - sy > smax) || (sx - sy < smin);
      end
      OP_MUL: begin
        full  = ux * uy;
        e.res = W'(full);
        e.hi  = W'(full >> W);
        e.c   = (full >> W) != 0;
      end
      OP_DIV: begin
        if (uy == 0) begin
          e.res = W'((1 << W) - 1);
          e.hi  = x;
          e.dz  = 1'b1;
        end else begin
          e.res = W'(ux / uy);
          e.hi  = W'(ux % uy);
        end
      end
      OP_SHL: begin
        e.res = W'(ux * 2);
        e.c   = ux >= (1 << (W - 1));
      end
      OP_SHR: begin
        e.res = W'(ux / 2);
        e.c   = (ux % 2) == 1;
      end
      OP_ROL:  e.res = W'(ux * 2 + ux / (1 << (W - 1)));
      OP_ROR:  e.res = W'(ux / 2 + (ux % 2) * (1 << (W - 1)));
      OP_AND:  e.res = x & y;
      OP_OR:   e.res = x | y;
      OP_XOR:  e.res = x ^ y;
      OP_NOR:  e.res = ~(x | y);
      OP_NAND: e.res = ~(x & y);
      OP_XNOR: e.res = ~(x ^ y);
      OP_GT:   e.res = (ux > uy) ? W'(1) : W'(0);
      OP_EQ:   e.res = (ux == uy) ? W'(1) : W'(0);
      default: e.res = '0;
    endcase
    e.z = (op == OP_MUL) ? (ux * uy == 0) : (e.res == '0);
    e.n = e.res[W-1];
    return e;
  endfunction

  // Call and return aligned to a falling edge.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic [3:0] op,
                        input int hold, input bit noise);
    exp_t e;
    int   lat, exp_lat, guard;
    e       = model(ta, tbv, op);
    exp_lat = (op == OP_MUL || op == OP_DIV) ? W + 1 : 1;
    a        = ta;
    b        = tbv;
    sel      = op;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < LIMIT) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    sel      = 4'($urandom);
    lat      = 1;
    while (!out_valid && lat < LIMIT) begin
      check("in_ready_busy", 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("latency",     32'(lat),         32'(exp_lat));
    check("result",      32'(result),      32'(e.res));
    check("result_hi",   32'(result_hi),   32'(e.hi));
    check("carry",       32'(carry),       32'(e.c));
    check("zero",        32'(zero),        32'(e.z));
    check("negative",    32'(negative),    32'(e.n));
    check("overflow",    32'(overflow),    32'(e.v));
    check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
    check("done_ready",  32'(in_ready),    32'd0);
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid = 1'b1;
        a        = W'($urandom);
        b        = W'($urandom);
        sel      = 4'($urandom);
      end
      @(negedge clk);
      check("hold_valid",  32'(out_valid), 32'd1);
      check("hold_result", 32'(result),    32'(e.res));
      check("hold_ready",  32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready),  32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sel       = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    32'(result),    32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    run_op(8'h0A, 8'h02, OP_ADD, 0, 1'b0);
    run_op(8'hF6, 8'h0A, OP_ADD, 0, 1'b0);
    run_op(8'h0A, 8'h0B, OP_SUB, 1, 1'b0);
    run_op(8'h7F, 8'h01, OP_ADD, 0, 1'b0);
    run_op(8'hF6, 8'h0A, OP_MUL, 0, 1'b0);
    run_op(8'hF6, 8'h0A, OP_DIV, 0, 1'b0);
    run_op(8'h55, 8'h00, OP_DIV, 0, 1'b0);
    run_op(8'hF0, 8'h3C, OP_XOR, 5, 1'b1);

    // Abort a multiply in its 4th BUSY cycle.
    check("pre_mul_ready", 32'(in_ready), 32'd1);
    a        = 8'hF6;
    b        = 8'h0A;
    sel      = OP_MUL;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valid",  32'(out_valid), 32'd0);
    check("abort_result", 32'(result),    32'd0);
    check("abort_hi",     32'(result_hi), 32'd0);
    check("abort_flags",  32'({carry, zero, negative, overflow, div_by_zero}), 32'd0);
    check("abort_busy0",  32'(busy),      32'd0);
    check("abort_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    check("abort_ready_after", 32'(in_ready), 32'd1);
    @(negedge clk);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      seen |= out_valid;
      @(negedge clk);
    end
    check("abort_no_result", 32'(seen), 32'd0);
    run_op(8'h12, 8'h12, OP_EQ, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] ra, rb;
      logic [3:0]   rop;
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      rop = 4'($urandom_range(0, 15));
      run_op(ra, rb, rop, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
